// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid skid buffer: registered valid/data/ready toward both sides,
// full throughput, in-order delivery, plus a wrapping count of downstream transfers.
module rv_skid_buffer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 main_valid_q, main_valid_d;
    logic [WIDTH-1:0]     main_data_q, main_data_d;
    logic [WIDTH-1:0]     skid_data_q, skid_data_d;
    logic                 in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

    logic in_fire;
    logic out_fire;

    // Both fires are formed from registered qualifiers only.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid_q & out_ready;

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign xfer_count = xfer_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            in_ready_q   <= 1'b1;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            in_ready_q   <= in_ready_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // Skid payload is only meaningful while FULL, so it carries no reset.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = ST_FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        main_valid_d = (state_d != ST_EMPTY);
        in_ready_d   = (state_d != ST_FULL);
        xfer_count_d = xfer_count_q;

        if (out_fire) begin
            xfer_count_d = xfer_count_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                end
            end
            ST_ONE: begin
                // Streaming replaces main directly; only a stalled accept spills to skid.
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    skid_data_d = in_data;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                end
            end
            default: begin
                main_data_d = main_data_q;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_skid_buffer.sv
// Self-checking bench for rv_skid_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rv_skid_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [7:0]  xfer_count;

    logic [7:0]  w_in_data;
    logic        w_in_ready;
    logic        w_out_valid;
    logic [7:0]  w_out_data;
    logic [1:0]  w_xfer_count;

    int vectors;
    int miscompares;

    logic [31:0] q[$];
    logic [31:0] last_out;
    int          model_cnt;

    assign w_in_data = in_data[7:0];

    rv_skid_buffer #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .xfer_count(xfer_count)
    );

    rv_skid_buffer #(.WIDTH(8), .CNT_WIDTH(2)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(w_in_data), .in_ready(w_in_ready),
        .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(out_ready),
        .xfer_count(w_xfer_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model consumes the inputs seen at the edge.
    task automatic tick();
        bit m_in_fire;
        bit m_out_fire;
        @(posedge clk);
        m_in_fire  = in_valid && (q.size() < 2);
        m_out_fire = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
            last_out  = '0;
            model_cnt = 0;
        end else begin
            if (m_out_fire) begin
                last_out = q.pop_front();
                model_cnt++;
            end
            if (m_in_fire) q.push_back(in_data);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hdead_beef; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b, expected 1", in_ready); end
        vectors++;
        if (xfer_count !== 8'd0) begin miscompares++; $display("FAIL reset_xfer_count: got %0d, expected 0", xfer_count); end
        vectors++;
        if (out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data: got %0h, expected 0", out_data); end
        vectors++;
        if (w_xfer_count !== 2'd0) begin miscompares++; $display("FAIL reset_w_xfer_count: got %0d, expected 0", w_xfer_count); end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
            miscompares++; $display("FAIL single_out: got valid=%0b data=%0h, expected valid=1 data=a5", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain_valid: got %0b, expected 0", out_valid); end
        vectors++;
        if (xfer_count !== 8'd1) begin miscompares++; $display("FAIL single_xfer_count: got %0d, expected 1", xfer_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0; in_data = 32'h99;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_in_ready: got %0b, expected 0", in_ready); end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            miscompares++; $display("FAIL bp_full_out: got valid=%0b data=%0h, expected valid=1 data=11", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            miscompares++; $display("FAIL bp_stall_hold: got valid=%0b data=%0h, expected valid=1 data=11", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h22) begin
            miscompares++; $display("FAIL bp_second_word: got valid=%0b data=%0h, expected valid=1 data=22", out_valid, out_data);
        end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_return: got %0b, expected 1", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 8'd2) begin
            miscompares++; $display("FAIL bp_drained: got valid=%0b count=%0d, expected valid=0 count=2", out_valid, xfer_count);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_data = i;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_word_%0d: got valid=%0b data=%0h ready=%0b, expected valid=1 data=%0h ready=1",
                         i, out_valid, out_data, in_ready, i);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 8'd10) begin
            miscompares++; $display("FAIL stream_end: got valid=%0b count=%0d, expected valid=0 count=10", out_valid, xfer_count);
        end
    endtask

    task automatic test_wrap();
        int exp_w[5];
        exp_w = '{1, 2, 3, 0, 1};
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_valid = (k <= 5);
            in_data  = 32'h40 + k;
            tick();
            if (k >= 2) begin
                vectors++;
                if (w_xfer_count !== 2'(exp_w[k-2])) begin
                    miscompares++;
                    $display("FAIL wrap_count_%0d: got %0d, expected %0d", k - 1, w_xfer_count, exp_w[k-2]);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h33;
        tick();
        in_data = 32'h44;
        tick();
        vectors++;
        if (in_ready !== 1'b0 || out_data !== 32'h33) begin
            miscompares++; $display("FAIL midrst_full: got ready=%0b data=%0h, expected ready=0 data=33", in_ready, out_data);
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midrst_after: got valid=%0b ready=%0b count=%0d, expected valid=0 ready=1 count=0",
                     out_valid, in_ready, xfer_count);
        end
        in_valid = 1'b1; in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            miscompares++; $display("FAIL midrst_next_word: got valid=%0b data=%0h, expected valid=1 data=55", out_valid, out_data);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || xfer_count !== 8'd1) begin
            miscompares++; $display("FAIL midrst_drain: got valid=%0b count=%0d, expected valid=0 count=1", out_valid, xfer_count);
        end
    endtask

    task automatic test_random();
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ready;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
            rst = 1'b0;
            exp_valid = (q.size() > 0);
            exp_data  = exp_valid ? q[0] : last_out;
            exp_ready = (q.size() < 2);
            vectors++;
            if (out_valid !== exp_valid || out_data !== exp_data || in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rand_out_c%0d: got valid=%0b data=%0h ready=%0b, expected valid=%0b data=%0h ready=%0b",
                         c, out_valid, out_data, in_ready, exp_valid, exp_data, exp_ready);
            end
            vectors++;
            if (xfer_count !== 8'(model_cnt) || w_xfer_count !== 2'(model_cnt)) begin
                miscompares++;
                $display("FAIL rand_count_c%0d: got %0d/%0d, expected %0d/%0d",
                         c, xfer_count, w_xfer_count, 8'(model_cnt), 2'(model_cnt));
            end
            vectors++;
            if (w_out_valid !== exp_valid || w_out_data !== exp_data[7:0] || w_in_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL rand_narrow_c%0d: got valid=%0b data=%0h ready=%0b, expected valid=%0b data=%0h ready=%0b",
                         c, w_out_valid, w_out_data, w_in_ready, exp_valid, exp_data[7:0], exp_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        vectors = 0; miscompares = 0;
        last_out = '0; model_cnt = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_skid_buffer.md
Name: rv_skid_buffer

Overview:
- Two-entry ready/valid skid buffer that sits directly upstream of the ready/valid consumer controller.
- Registers the producer's valid/data and presents them to the consumer. Its own ready is a pure register output, so the consumer's registered ready never forms a combinational path back to the producer.
- Sustains one transfer per cycle and preserves ordering.
- Provides a wrapping count of completed downstream transfers for debug and verification.

Parameters:
- WIDTH, 32, payload width in bits.
- CNT_WIDTH, 8, width of the downstream transfer counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  producer payload.
- in_ready  output  1  buffer can accept a word this cycle; registered.
- out_valid  output  1  out_data holds a word for the consumer; registered.
- out_data  output  WIDTH  payload to the consumer; registered.
- out_ready  input  1  consumer accepts out_data this cycle.
- xfer_count  output  CNT_WIDTH  number of completed downstream transfers, mod 2^CNT_WIDTH.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - A transfer happens only on a fire at a posedge.
- Storage: main register (main_valid, main_data) drives out_valid/out_data directly; one skid register (skid_valid, skid_data).
- States:
  - EMPTY: main and skid both empty.
  - ONE: main holds a word, skid empty.
  - FULL: main and skid both hold a word.
- Reset (rst=1 at posedge, from any state, including mid-transfer):
  - State goes to EMPTY.
  - out_valid=0, out_data=0, in_ready=1, xfer_count=0.
  - Skid contents are discarded; no fire is honoured in the reset cycle.
- Transitions:
  - EMPTY, in_fire: main<=in_data, goes to ONE. No in_fire: stays EMPTY.
  - ONE, in_fire & out_fire: main<=in_data, stays ONE (full-throughput streaming).
  - ONE, in_fire only: skid<=in_data, goes to FULL, in_ready<=0.
  - ONE, out_fire only: goes to EMPTY, out_valid<=0.
  - ONE, neither: holds.
  - FULL: in_ready=0, so in_fire is impossible. On out_fire: main<=skid_data, goes to ONE, in_ready<=1. Otherwise holds.
- in_ready is 1 in EMPTY and ONE, 0 in FULL, and always comes straight from a flop.
- Latency: a word accepted at posedge N appears on out_valid/out_data after posedge N when the buffer was EMPTY, or after the preceding word drains.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Ordering: words leave in exactly the order they were accepted; no drops, no duplicates.
- in_data is ignored when in_fire=0. out_ready is ignored when out_valid=0.
- xfer_count increments by 1 on each out_fire and wraps from 2^CNT_WIDTH-1 to 0.
- When out_valid=0, out_data keeps the last value and is don't-care to the consumer.

Test Plan:
- Reset: after rst pulse, in_valid=0 for 2 cycles -> out_valid=0, in_ready=1, xfer_count=0, out_data=0.
- Single word: in_data=0xA5 for one cycle with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=0xA5; following cycle out_valid=0, xfer_count=1.
- Backpressure: out_ready=0, send 0x11 then 0x22 -> after 2 cycles in_ready=0, out_data=0x11 held. Raise out_ready -> outputs 0x11 then 0x22 on consecutive cycles, in_ready returns to 1, xfer_count=2.
- Streaming: in_valid=1, out_ready=1, data 1..10 on consecutive cycles -> out_data 1..10 on consecutive cycles one cycle later, in_ready stays 1, xfer_count=10.
- Wrap: CNT_WIDTH=2, 5 transfers -> xfer_count sequence 1,2,3,0,1.
- Mid-operation reset: reach FULL (0x33 in main, 0x44 in skid), assert rst for one cycle with out_ready=1 -> out_valid=0, in_ready=1, xfer_count=0. 0x44 is never emitted; next word sent is the first one out.
